seven_seg_mux: RTL and testbench

- Multi-digit, time-multiplexed seven-segment driver: successor to the single-digit hex decoder.
- Takes a packed hex word plus per-digit decimal-point and enable masks, scans one digit at a time, and drives shared segment lines and per-digit anode lines.
- Double-buffered input, anti-ghosting blank slot, optional leading-zero suppression, configurable output polarity.
- Sits between the CPU debug/IO register and the board display pins.

---
 rtl/seven_seg_mux.sv | 187 ++++++++++++++++++
 tb/tb_seven_seg_mux.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_mux.sv
// rtl/seven_seg_mux.sv - multi-digit time-multiplexed seven-segment display driver
module seven_seg_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int LZ_SUPPRESS    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      load,
    output logic [6:0]                seg,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic                      frame_done
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRESC_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [6:0]          SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                DP_OFF     = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] act_value_q, act_value_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;
    logic [4*NUM_DIGITS-1:0] pend_value_q, pend_value_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_out_q, dp_out_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    frame_done_q, frame_done_d;

    logic                    slot_end;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    suppress;
    logic [3:0]              nib;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [6:0]              seg_low;
    logic                    dp_low;
    logic [NUM_DIGITS-1:0]   anode_hi;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0011000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b0100111;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Scan counters and double buffer: swap pending into active only at the frame boundary
    always_comb begin
        slot_end     = (presc_q == PRESC_LAST);
        frame_end    = slot_end && (idx_q == IDX_LAST);
        presc_d      = slot_end ? '0 : presc_q + PRESC_W'(1);
        idx_d        = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        act_value_d  = act_value_q;
        act_dp_d     = act_dp_q;
        act_en_d     = act_en_q;
        pend_value_d = pend_value_q;
        pend_dp_d    = pend_dp_q;
        pend_en_d    = pend_en_q;
        pend_valid_d = pend_valid_q;
        if (frame_end) begin
            // A load landing on the swap edge bypasses pending and wins over older data
            if (load) begin
                act_value_d = value;
                act_dp_d    = dp;
                act_en_d    = digit_en;
            end else if (pend_valid_q) begin
                act_value_d = pend_value_q;
                act_dp_d    = pend_dp_q;
                act_en_d    = pend_en_q;
            end
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_value_d = value;
            pend_dp_d    = dp;
            pend_en_d    = digit_en;
            pend_valid_d = 1'b1;
        end
    end

    // Output pattern for the upcoming cycle, derived from next-state so pins stay registered
    always_comb begin
        // Walk from the most significant digit down; suppression ends at the first
        // enabled digit that is nonzero or carries a decimal point
        suppress = (LZ_SUPPRESS != 0);
        blank    = '0;
        nib      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib      = act_value_d[4*i +: 4];
            blank[i] = !act_en_d[i] ||
                       (suppress && (nib == 4'h0) && !act_dp_d[i] && (i != 0));
            if (act_en_d[i] && ((nib != 4'h0) || act_dp_d[i])) begin
                suppress = 1'b0;
            end
        end
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        anode_hi  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx_d) begin
                cur_nib   = act_value_d[4*i +: 4];
                cur_dp    = act_dp_d[i];
                cur_blank = blank[i];
                anode_hi[i] = (presc_d != '0);
            end
        end
        seg_low      = cur_blank ? 7'h7F : hex_to_seg(cur_nib);
        dp_low       = cur_blank || !cur_dp;
        seg_d        = (SEG_ACTIVE_LOW != 0) ? seg_low : ~seg_low;
        dp_out_d     = (SEG_ACTIVE_LOW != 0) ? dp_low : ~dp_low;
        anode_d      = (AN_ACTIVE_LOW != 0) ? ~anode_hi : anode_hi;
        frame_done_d = (idx_d == IDX_LAST) && (presc_d == PRESC_LAST);
    end

    // State and output registers; reset parks every pin inactive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            act_value_q  <= '0;
            act_dp_q     <= '0;
            act_en_q     <= '0;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            pend_valid_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_out_q     <= DP_OFF;
            anode_q      <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            act_value_q  <= act_value_d;
            act_dp_q     <= act_dp_d;
            act_en_q     <= act_en_d;
            pend_value_q <= pend_value_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            dp_out_q     <= dp_out_d;
            anode_q      <= anode_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp_out     = dp_out_q;
    assign anode      = anode_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// tb/tb_seven_seg_mux.sv - directed self-checking bench for seven_seg_mux
module tb_seven_seg_mux;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic        load;
    logic [6:0]  seg_a, seg_b;
    logic        dp_out_a, dp_out_b;
    logic [3:0]  anode_a, anode_b;
    logic        fd_a, fd_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    seven_seg_mux #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .LZ_SUPPRESS(1)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .digit_en(digit_en), .load(load),
        .seg(seg_a), .dp_out(dp_out_a), .anode(anode_a), .frame_done(fd_a)
    );

    seven_seg_mux #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0), .LZ_SUPPRESS(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .digit_en(digit_en), .load(load),
        .seg(seg_b), .dp_out(dp_out_b), .anode(anode_b), .frame_done(fd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        value    = v;
        dp       = d;
        digit_en = e;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic goto_frame_start();
        while (cyc % 16 != 0) tick();
    endtask

    // es holds {d3,d2,d1,d0} 7-bit patterns; ed holds expected dp_out level per digit
    task automatic check_to_frame_end(input int inst, input logic [27:0] es, input logic [3:0] ed);
        int p;
        int d;
        logic [3:0] ea;
        logic last;
        for (int n = 0; n < 16; n++) begin
            p = cyc % 4;
            d = (cyc / 4) % 4;
            if (inst == 0) begin
                ea = (p == 0) ? 4'hF : ~(4'b0001 << d);
                check_eq("seg_a", {25'd0, seg_a}, {25'd0, es[7*d +: 7]});
                check_eq("dp_a", {31'd0, dp_out_a}, {31'd0, ed[d]});
                check_eq("anode_a", {28'd0, anode_a}, {28'd0, ea});
                check_eq("fd_a", {31'd0, fd_a}, {31'd0, (cyc % 16 == 15)});
            end else begin
                ea = (p == 0) ? 4'h0 : (4'b0001 << d);
                check_eq("seg_b", {25'd0, seg_b}, {25'd0, es[7*d +: 7]});
                check_eq("dp_b", {31'd0, dp_out_b}, {31'd0, ed[d]});
                check_eq("anode_b", {28'd0, anode_b}, {28'd0, ea});
                check_eq("fd_b", {31'd0, fd_b}, {31'd0, (cyc % 16 == 15)});
            end
            last = (cyc % 16 == 15);
            tick();
            if (last) break;
        end
    endtask

    initial begin
        logic [3:0] ea;
        rst_n    = 1'b0;
        value    = '0;
        dp       = '0;
        digit_en = '0;
        load     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Reset asserted mid-scan must blank pins at once
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_seg_a", {25'd0, seg_a}, 32'h7F);
        check_eq("rst_anode_a", {28'd0, anode_a}, 32'hF);
        check_eq("rst_dp_a", {31'd0, dp_out_a}, 32'h1);
        check_eq("rst_fd_a", {31'd0, fd_a}, 32'h0);
        check_eq("rst_seg_b", {25'd0, seg_b}, 32'h00);
        check_eq("rst_anode_b", {28'd0, anode_b}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        // Idle scan: blank slot then one-hot anode, frame_done every 16 cycles
        for (int n = 0; n < 33; n++) begin
            ea = ((cyc % 4) == 0) ? 4'hF : ~(4'b0001 << ((cyc / 4) % 4));
            check_eq("idle_anode", {28'd0, anode_a}, {28'd0, ea});
            check_eq("idle_seg", {25'd0, seg_a}, 32'h7F);
            check_eq("idle_fd", {31'd0, fd_a}, {31'd0, (cyc % 16 == 15)});
            tick();
        end

        // Decode/scan
        do_load(16'h12AF, 4'b0000, 4'hF);
        goto_frame_start();
        check_to_frame_end(0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111);

        // Leading zero suppression
        do_load(16'h0050, 4'b0000, 4'hF);
        goto_frame_start();
        check_to_frame_end(0, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111);
        do_load(16'h0050, 4'b0100, 4'hF);
        goto_frame_start();
        check_to_frame_end(0, {7'h7F, 7'h40, 7'h12, 7'h40}, 4'b1011);

        // Load during digit 1 slot: rest of frame keeps old data
        while (cyc % 16 != 5) tick();
        do_load(16'h1111, 4'b0000, 4'hF);
        check_to_frame_end(0, {7'h7F, 7'h40, 7'h12, 7'h40}, 4'b1011);
        check_to_frame_end(0, {7'h79, 7'h79, 7'h79, 7'h79}, 4'b1111);

        // Two loads in one frame: second wins
        do_load(16'h0123, 4'b0000, 4'hF);
        while (cyc % 16 != 8) tick();
        do_load(16'h4567, 4'b0000, 4'hF);
        check_to_frame_end(0, {7'h79, 7'h79, 7'h79, 7'h79}, 4'b1111);
        check_to_frame_end(0, {7'h19, 7'h12, 7'h02, 7'h78}, 4'b1111);

        // Load coincident with swap overrides an older pending load
        do_load(16'h3333, 4'b0000, 4'hF);
        while (cyc % 16 != 15) tick();
        check_eq("fd_before_swap", {31'd0, fd_a}, 32'h1);
        do_load(16'hBEEF, 4'b0000, 4'hF);
        check_eq("pend_valid", {31'd0, u_a.pend_valid_q}, 32'h0);
        check_to_frame_end(0, {7'h03, 7'h06, 7'h06, 7'h0E}, 4'b1111);

        // High-true polarity instance with only digit 0 enabled
        do_load(16'h0008, 4'b0000, 4'b0001);
        goto_frame_start();
        check_to_frame_end(1, {7'h00, 7'h00, 7'h00, 7'h7F}, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
